// File: rtl/ps2_key_event_controller.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_controller
// Purpose  : Turns PS/2 scan-code bytes into queued key press/release events.
// Revision : 1.0
// ============================================================================
module ps2_key_event_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [7:0]                        scan_data_i,
  input  logic                              scan_valid_i,
  input  logic                              flush_i,
  input  logic                              event_ready_i,
  output logic                              event_valid_o,
  output logic [2:0]                        event_key_o,
  output logic                              event_press_o,
  output logic [5:0]                        key_held_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
  output logic                              overflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BAT   = 8'hAA;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [5:0]    held_q, held_d;

  logic          code_mapped;
  logic [2:0]    code_key;

  logic          ev_push;
  logic          ev_press;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic          fifo_pop;
  logic          fifo_full;
  logic          push_ok;
  logic          push_drop;

  always_comb begin
    code_mapped = 1'b1;
    code_key    = 3'd0;
    case (scan_data_i)
      8'h5A:   code_key = 3'd0;
      8'h23:   code_key = 3'd1;
      8'h2B:   code_key = 3'd2;
      8'h3B:   code_key = 3'd3;
      8'h42:   code_key = 3'd4;
      8'h76:   code_key = 3'd5;
      default: code_mapped = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a prefix left dangling too long falls back to IDLE
  always_comb begin
    state_d = state_q;
    if (scan_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_data_i == CODE_BREAK)    state_d = ST_BRK;
          else if (scan_data_i == CODE_EXT) state_d = ST_EXT;
        end
        ST_EXT:  state_d = (scan_data_i == CODE_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
    end
    if (flush_i) state_d = ST_IDLE;
  end

  always_comb begin
    tmo_d = tmo_q + TW'(1);
    if (scan_valid_i || flush_i || state_d == ST_IDLE) tmo_d = '0;
  end

  // Output logic: held-bitmap update and event generation
  always_comb begin
    held_d   = held_q;
    ev_push  = 1'b0;
    ev_press = 1'b0;
    if (scan_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_data_i == CODE_BAT) begin
            held_d = '0;
          end else if (code_mapped && !held_q[code_key]) begin
            held_d[code_key] = 1'b1;
            ev_push          = 1'b1;
            ev_press         = 1'b1;
          end
        end
        ST_BRK: begin
          if (code_mapped && held_q[code_key]) begin
            held_d[code_key] = 1'b0;
            ev_push          = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_q <= '0;
      tmo_q  <= '0;
    end else if (flush_i) begin
      held_q <= '0;
      tmo_q  <= '0;
    end else begin
      held_q <= held_d;
      tmo_q  <= tmo_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign fifo_pop  = (count_q != '0) && event_ready_i;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign push_ok   = ev_push && (!fifo_full || fifo_pop);
  assign push_drop = ev_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= {code_key, ev_press};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok)  wr_q <= wr_q + PW'(1);
      if (fifo_pop) rd_q <= rd_q + PW'(1);
      case ({push_ok, fifo_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      ovf_q <= ovf_q | push_drop;
    end
  end

  assign event_valid_o = (count_q != '0);
  assign event_key_o   = mem_q[rd_q][3:1];
  assign event_press_o = mem_q[rd_q][0];
  assign key_held_o    = held_q;
  assign fifo_count_o  = count_q;
  assign overflow_o    = ovf_q;

endmodule
`default_nettype wire
